// File: rtl/div_rs_pkg.sv
// Shared types for the divide reservation station: packets, CDB, dispatch and entry records.
package div_rs_pkg;

  localparam int unsigned ROB_DEPTH    = 16;
  localparam int unsigned TAG_W        = $clog2(ROB_DEPTH);
  localparam int unsigned XLEN         = 32;
  localparam int unsigned DIV_RS_DEPTH = 4;

  typedef enum logic [1:0] {OpDiv, OpDivu, OpRem, OpRemu} div_op_e;

  typedef struct packed {
    div_op_e           op;
    logic [TAG_W-1:0]  rob_tag;
    logic [XLEN-1:0]   rs1_v;
    logic [XLEN-1:0]   rs2_v;
  } fu_pkt_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob_tag;
    logic [XLEN-1:0]   data;
  } cdb_t;

  typedef struct packed {
    fu_pkt_t           pkt;
    logic              rs1_rdy;
    logic              rs2_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
  } div_rs_disp_t;

  typedef struct packed {
    logic              valid;
    fu_pkt_t           pkt;
    logic              rs1_rdy;
    logic              rs2_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
  } div_rs_entry_t;

  // True when a still-waiting source is satisfied by this cycle's broadcast.
  function automatic logic cdb_hit(cdb_t c, logic rdy, logic [TAG_W-1:0] tag);
    return c.valid && !rdy && (c.rob_tag == tag);
  endfunction

endpackage

// File: rtl/div_rs_age_matrix.sv
// Age matrix for reservation stations: row i bit j set means entry i is older than entry j.
// Grants the single oldest requester; reusable by any station.
module rs_age_matrix #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] gnt_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] others;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i] & ~free_i;
      if (valid_i[i] && !alloc_i[i]) age_d[i] = age_d[i] | alloc_i;
      if (alloc_i[i]) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_i) age_q[i] <= '0;
      else       age_q[i] <= age_d[i];
    end
  end

  // A requester wins when it is older than every other requester.
  always_comb begin
    gnt_o  = '0;
    others = '0;
    for (int i = 0; i < DEPTH; i++) begin
      others    = ~req_i;
      others[i] = 1'b1;
      gnt_o[i]  = req_i[i] && (&(age_q[i] | others));
    end
  end

endmodule

// File: rtl/div_rs.sv
// Reservation station feeding the divider; issues the oldest ready entry while the divider is idle.
// Optional DIV_RS_CDB_BYPASS_EN lets a same-cycle CDB broadcast complete an entry for issue.
module div_rs
  import div_rs_pkg::*;
#(
  parameter int unsigned DEPTH = DIV_RS_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         disp_valid,
  input  logic [$bits(div_rs_disp_t)-1:0] disp_in,
  output logic                         disp_ready,
  input  logic [$bits(cdb_t)-1:0]      cdb_in,
  input  logic                         div_busy,
  output logic                         div_en,
  output logic [$bits(fu_pkt_t)-1:0]   div_pkt_out,
  output logic [$clog2(DEPTH):0]       rs_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  div_rs_disp_t  disp;
  cdb_t          cdb;
  div_rs_entry_t ent_q [DEPTH];
  div_rs_entry_t ent_d [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] valid_vec, hit1, hit2, req, gnt, alloc_oh, alloc_v, free_v;
  logic             alloc_found, disp_fire, issue, age_clr;
  fu_pkt_t          pkt_sel;

  assign disp = disp_in;
  assign cdb  = cdb_in;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      hit1[i]      = cdb_hit(cdb, ent_q[i].rs1_rdy, ent_q[i].rs1_tag);
      hit2[i]      = cdb_hit(cdb, ent_q[i].rs2_rdy, ent_q[i].rs2_tag);
`ifdef DIV_RS_CDB_BYPASS_EN
      req[i] = ent_q[i].valid && (ent_q[i].rs1_rdy || hit1[i]) && (ent_q[i].rs2_rdy || hit2[i]);
`else
      req[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
`endif
    end
  end

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Full-ness comes from registered count only; a same-cycle issue does not free a slot.
  assign disp_ready = (count_q != CntW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign issue      = (|req) && !div_busy && !stall && !flush && !rst;
  assign alloc_v    = disp_fire ? alloc_oh : '0;
  assign free_v     = issue ? gnt : '0;
  assign age_clr    = rst || flush;

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk_i   (clk),
    .clr_i   (age_clr),
    .valid_i (valid_vec),
    .alloc_i (alloc_v),
    .free_i  (free_v),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  always_comb begin
    pkt_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) begin
        pkt_sel = ent_q[i].pkt;
`ifdef DIV_RS_CDB_BYPASS_EN
        if (hit1[i]) pkt_sel.rs1_v = cdb.data;
        if (hit2[i]) pkt_sel.rs2_v = cdb.data;
`endif
      end
    end
  end

  assign div_en      = issue;
  assign div_pkt_out = issue ? pkt_sel : '0;
  assign rs_count    = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (free_v[i]) begin
        ent_d[i].valid = 1'b0;
      end else if (ent_q[i].valid) begin
        if (hit1[i]) begin
          ent_d[i].rs1_rdy   = 1'b1;
          ent_d[i].pkt.rs1_v = cdb.data;
        end
        if (hit2[i]) begin
          ent_d[i].rs2_rdy   = 1'b1;
          ent_d[i].pkt.rs2_v = cdb.data;
        end
      end
      if (alloc_v[i]) begin
        ent_d[i].valid   = 1'b1;
        ent_d[i].pkt     = disp.pkt;
        ent_d[i].rs1_tag = disp.rs1_tag;
        ent_d[i].rs2_tag = disp.rs2_tag;
        ent_d[i].rs1_rdy = disp.rs1_rdy || cdb_hit(cdb, disp.rs1_rdy, disp.rs1_tag);
        ent_d[i].rs2_rdy = disp.rs2_rdy || cdb_hit(cdb, disp.rs2_rdy, disp.rs2_tag);
        if (cdb_hit(cdb, disp.rs1_rdy, disp.rs1_tag)) ent_d[i].pkt.rs1_v = cdb.data;
        if (cdb_hit(cdb, disp.rs2_rdy, disp.rs2_tag)) ent_d[i].pkt.rs2_v = cdb.data;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (disp_fire && !issue)      count_d = count_q + CntW'(1);
    else if (!disp_fire && issue) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_div_rs.sv
// Self-checking bench for div_rs: directed scenarios then random traffic against an age-ordered
// queue model. Build with +define+DIV_RS_CDB_BYPASS_EN to check the bypass variant.
module tb_div_rs;
  import div_rs_pkg::*;

  logic         clk = 1'b0;
  logic         rst, flush, stall, disp_valid, div_busy;
  div_rs_disp_t disp_in;
  cdb_t         cdb_in;
  logic         disp_ready, div_en;
  fu_pkt_t      div_pkt_out;
  logic [2:0]   rs_count;

  div_rs #(
    .DEPTH (DIV_RS_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall       (stall),
    .disp_valid  (disp_valid),
    .disp_in     (disp_in),
    .disp_ready  (disp_ready),
    .cdb_in      (cdb_in),
    .div_busy    (div_busy),
    .div_en      (div_en),
    .div_pkt_out (div_pkt_out),
    .rs_count    (rs_count)
  );

  always #5 clk = ~clk;

  // Model: queue ordered oldest-first.
  typedef struct {
    fu_pkt_t    pkt;
    bit         r1;
    bit         r2;
    logic [3:0] t1;
    logic [3:0] t2;
  } m_ent_t;

  m_ent_t  mq[$];
  int      total = 0;
  int      bad = 0;
  bit      exp_issue;
  int      exp_idx;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cdb_hits(input bit rdy, input logic [3:0] tag);
    return !rdy && cdb_in.valid && (cdb_in.rob_tag == tag);
  endfunction

  function automatic bit eff_ready(input m_ent_t e);
`ifdef DIV_RS_CDB_BYPASS_EN
    return (e.r1 || cdb_hits(e.r1, e.t1)) && (e.r2 || cdb_hits(e.r2, e.t2));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  task automatic idle_inputs();
    flush      = 1'b0;
    stall      = 1'b0;
    disp_valid = 1'b0;
    disp_in    = '0;
    cdb_in     = '0;
  endtask

  task automatic set_disp(input int op, input int rtag, input logic [31:0] v1, input logic [31:0] v2,
                          input bit r1, input bit r2, input int t1, input int t2);
    disp_valid          = 1'b1;
    disp_in.pkt.op      = div_op_e'(op[1:0]);
    disp_in.pkt.rob_tag = rtag[3:0];
    disp_in.pkt.rs1_v   = v1;
    disp_in.pkt.rs2_v   = v2;
    disp_in.rs1_rdy     = r1;
    disp_in.rs2_rdy     = r2;
    disp_in.rs1_tag     = t1[3:0];
    disp_in.rs2_tag     = t2[3:0];
  endtask

  task automatic set_cdb(input int tag, input logic [31:0] data);
    cdb_in.valid   = 1'b1;
    cdb_in.rob_tag = tag[3:0];
    cdb_in.data    = data;
  endtask

  // Inputs are already applied at the negedge; compare just after, well before the posedge.
  task automatic sample();
    bit      found;
    fu_pkt_t exp_pkt;
    #2;
    found   = 1'b0;
    exp_idx = -1;
    for (int k = 0; k < mq.size(); k++) begin
      if (!found && eff_ready(mq[k])) begin
        found   = 1'b1;
        exp_idx = k;
      end
    end
    exp_issue = found && !div_busy && !stall && !flush && !rst;
    exp_pkt   = '0;
    if (exp_issue) begin
      exp_pkt = mq[exp_idx].pkt;
      if (cdb_hits(mq[exp_idx].r1, mq[exp_idx].t1)) exp_pkt.rs1_v = cdb_in.data;
      if (cdb_hits(mq[exp_idx].r2, mq[exp_idx].t2)) exp_pkt.rs2_v = cdb_in.data;
    end
    check("disp_ready", 128'(disp_ready), 128'(mq.size() != 4));
    check("rs_count", 128'(rs_count), 128'(mq.size()));
    check("div_en", 128'(div_en), 128'(exp_issue));
    check("div_pkt_out", 128'(div_pkt_out), 128'(exp_pkt));
  endtask

  task automatic finish_cyc();
    bit     fire;
    m_ent_t e;
    @(posedge clk);
    fire = disp_valid && (mq.size() != 4);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (exp_issue) mq.delete(exp_idx);
      for (int k = 0; k < mq.size(); k++) begin
        e = mq[k];
        if (cdb_hits(e.r1, e.t1)) begin e.r1 = 1'b1; e.pkt.rs1_v = cdb_in.data; end
        if (cdb_hits(e.r2, e.t2)) begin e.r2 = 1'b1; e.pkt.rs2_v = cdb_in.data; end
        mq[k] = e;
      end
      if (fire) begin
        e.pkt = disp_in.pkt;
        e.r1  = disp_in.rs1_rdy;
        e.r2  = disp_in.rs2_rdy;
        e.t1  = disp_in.rs1_tag;
        e.t2  = disp_in.rs2_tag;
        if (cdb_hits(e.r1, e.t1)) begin e.r1 = 1'b1; e.pkt.rs1_v = cdb_in.data; end
        if (cdb_hits(e.r2, e.t2)) begin e.r2 = 1'b1; e.pkt.rs2_v = cdb_in.data; end
        mq.push_back(e);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic go();
    sample();
    finish_cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    div_busy = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    go();  // reset values: ready=1, count=0, en=0, pkt=0

    // Both operands ready at dispatch: issue the next cycle.
    set_disp(0, 1, 100, 7, 1, 1, 0, 0);
    go();
    sample();
    check("t1_en", 128'(div_en), 128'(1));
    check("t1_rs1", 128'(div_pkt_out.rs1_v), 128'(100));
    check("t1_rs2", 128'(div_pkt_out.rs2_v), 128'(7));
    finish_cyc();
    div_busy = 1'b1;
    go();
    div_busy = 1'b0;
    go();

    // Older A waits on tag 5, younger B ready.
    set_disp(2, 2, 20, 0, 1, 0, 0, 5);
    go();
    set_disp(1, 3, 9, 3, 1, 1, 0, 0);
    go();
    set_cdb(5, 3);
    sample();
`ifdef DIV_RS_CDB_BYPASS_EN
    check("t2_first_tag", 128'(div_pkt_out.rob_tag), 128'(2));
    check("t2_first_rs2", 128'(div_pkt_out.rs2_v), 128'(3));
`else
    check("t2_first_tag", 128'(div_pkt_out.rob_tag), 128'(3));
`endif
    finish_cyc();
    div_busy = 1'b1;
    go();
    go();
    div_busy = 1'b0;
    sample();
`ifdef DIV_RS_CDB_BYPASS_EN
    check("t2_second_tag", 128'(div_pkt_out.rob_tag), 128'(3));
`else
    check("t2_second_tag", 128'(div_pkt_out.rob_tag), 128'(2));
    check("t2_second_rs2", 128'(div_pkt_out.rs2_v), 128'(3));
`endif
    finish_cyc();
    div_busy = 1'b1;
    go();
    div_busy = 1'b0;
    go();

    // Fill with nothing ready, then try a fifth dispatch.
    for (int k = 0; k < 4; k++) begin
      set_disp(3, 8 + k, 32'(50 + k), 2, 0, 1, 10 + k, 0);
      go();
    end
    $display("note: dispatching into a full station on purpose; it must be dropped");
    set_disp(0, 15, 1, 1, 1, 1, 0, 0);
    sample();
    check("t3_ready", 128'(disp_ready), 128'(0));
    check("t3_cnt", 128'(rs_count), 128'(4));
    finish_cyc();
    sample();
    check("t3_cnt_after", 128'(rs_count), 128'(4));
    finish_cyc();

    // Two entries ready but divider busy for 17 cycles.
    div_busy = 1'b1;
    set_cdb(10, 200);
    go();
    set_cdb(11, 300);
    go();
    for (int k = 0; k < 17; k++) begin
      sample();
      check("t4_hold", 128'(div_en), 128'(0));
      finish_cyc();
    end
    div_busy = 1'b0;
    sample();
    check("t4_oldest", 128'(div_pkt_out.rob_tag), 128'(8));
    check("t4_oldest_rs1", 128'(div_pkt_out.rs1_v), 128'(200));
    finish_cyc();
    div_busy = 1'b1;
    sample();
    check("t4_pulse", 128'(div_en), 128'(0));
    finish_cyc();

    // Flush with three entries, one ready, divider idle.
    div_busy = 1'b0;
    flush    = 1'b1;
    sample();
    check("t5_en", 128'(div_en), 128'(0));
    finish_cyc();
    sample();
    check("t5_cnt", 128'(rs_count), 128'(0));
    check("t5_ready", 128'(disp_ready), 128'(1));
    finish_cyc();
    set_cdb(12, 77);
    go();
    sample();
    check("t5_stale", 128'(div_en), 128'(0));
    finish_cyc();

    // Wakeup-to-issue latency on tag 9.
    set_disp(1, 6, 0, 5, 0, 1, 9, 0);
    go();
    set_cdb(9, 32'hFFFF_FFFF);
    sample();
`ifdef DIV_RS_CDB_BYPASS_EN
    check("t6_en", 128'(div_en), 128'(1));
    check("t6_rs1", 128'(div_pkt_out.rs1_v), 128'(32'hFFFF_FFFF));
    finish_cyc();
`else
    check("t6_en", 128'(div_en), 128'(0));
    finish_cyc();
    sample();
    check("t6_en_late", 128'(div_en), 128'(1));
    check("t6_rs1", 128'(div_pkt_out.rs1_v), 128'(32'hFFFF_FFFF));
    finish_cyc();
`endif
    div_busy = 1'b1;
    go();
    div_busy = 1'b0;
    go();

    // Random traffic; dispatch only when the model says there is room.
    for (int n = 0; n < 400; n++) begin
      flush    = ($urandom_range(0, 39) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      div_busy = ($urandom_range(0, 2) == 0);
      if (mq.size() < 4 && $urandom_range(0, 1) == 1) begin
        set_disp($urandom_range(0, 3), $urandom_range(0, 15), $urandom, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 1) set_cdb($urandom_range(0, 7), $urandom);
      go();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
